// File: rtl/alu_pkg.sv
// Shared types for the byte-serial ALU sequencer: command codes, FSM states,
// and the helpers that classify commands.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD0 = 3'b000,
    ADD1 = 3'b001,
    ABSJ = 3'b010,
    XOR  = 3'b011,
    ROT  = 3'b100,
    AND  = 3'b101,
    OR   = 3'b110,
    ADD7 = 3'b111
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic logic is_add(alu_cmd_t cmd);
    return (cmd == ADD0) || (cmd == ADD1) || (cmd == ADD7);
  endfunction

  // Only commands whose bytes combine independently, or through the carry
  // chain, can be split across cycles.
  function automatic logic is_legal_seq(alu_cmd_t cmd);
    return is_add(cmd) || (cmd == XOR) || (cmd == AND);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the control unit (master) and
// the byte-serial ALU sequencer (slave).
interface alu_seq_if #(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic               req_valid;
  logic               req_ready;
  alu_pkg::alu_cmd_t  req_cmd;
  logic [W-1:0]       req_a;
  logic [W-1:0]       req_b;
  logic               req_cin;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_rslt;
  logic               rsp_cout;
  logic               rsp_pari;
  logic               rsp_illegal;

  modport master (
    output req_valid, req_cmd, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_cout, rsp_pari, rsp_illegal
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_cout, rsp_pari, rsp_illegal
  );

endinterface

// File: rtl/alu_seq.sv
// Byte-serial sequencer: feeds an 8-bit ALU one byte per cycle, LSB first,
// chaining the carry. Define ALU_SEQ_PARITY_EN to accumulate result parity.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output alu_cmd_t    alu_cmd,
  output logic [7:0]  alu_inA,
  output logic [7:0]  alu_inB,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  alu_cmd_t          cmd_q;
  logic [W-1:0]      a_q, b_q, rslt_q;
  logic              carry_q;
  logic              illegal_q;
`ifdef ALU_SEQ_PARITY_EN
  logic              parity_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) state_d = is_legal_seq(bus.req_cmd) ? RUN : DONE;
      RUN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == DONE);
    alu_cmd       = ADD0;
    alu_inA       = '0;
    alu_inB       = '0;
    alu_sc_i      = 1'b0;
    if (state_q == RUN) begin
      alu_cmd  = cmd_q;
      alu_inA  = a_q[8*idx_q +: 8];
      alu_inB  = b_q[8*idx_q +: 8];
      alu_sc_i = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cmd_q     <= ADD0;
      a_q       <= '0;
      b_q       <= '0;
      rslt_q    <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SEQ_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          cmd_q     <= bus.req_cmd;
          a_q       <= bus.req_a;
          b_q       <= bus.req_b;
          idx_q     <= '0;
          carry_q   <= is_add(bus.req_cmd) & bus.req_cin;
          rslt_q    <= '0;
          illegal_q <= ~is_legal_seq(bus.req_cmd);
`ifdef ALU_SEQ_PARITY_EN
          parity_q  <= 1'b0;
`endif
        end
        RUN: begin
          rslt_q[8*idx_q +: 8] <= alu_rslt;
          carry_q              <= is_add(cmd_q) & alu_sc_o;
`ifdef ALU_SEQ_PARITY_EN
          parity_q             <= parity_q ^ (^alu_rslt);
`endif
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Response fields are plain registers, so they stay frozen throughout DONE.
  assign bus.rsp_rslt    = rslt_q;
  assign bus.rsp_cout    = carry_q;
  assign bus.rsp_illegal = illegal_q;
`ifdef ALU_SEQ_PARITY_EN
  assign bus.rsp_pari    = parity_q;
`else
  assign bus.rsp_pari    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (NBYTES=2) with a behavioural
// 8-bit ALU attached to the alu_* port.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_SEQ_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  alu_cmd_t   alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt;
  logic       alu_sc_i, alu_sc_o;

  int passed = 0;
  int total  = 0;

  alu_seq_if #(.NBYTES(2)) bus ();

  alu_seq #(.NBYTES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_cmd  (alu_cmd),
    .alu_inA  (alu_inA),
    .alu_inB  (alu_inB),
    .alu_sc_i (alu_sc_i),
    .alu_rslt (alu_rslt),
    .alu_sc_o (alu_sc_o)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU as the parent would instantiate it.
  always_comb begin
    alu_rslt = 8'h00;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      ADD0, ADD1, ADD7: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_sc_i};
      XOR:              alu_rslt = alu_inA ^ alu_inB;
      AND:              alu_rslt = alu_inA & alu_inB;
      default:          alu_rslt = alu_inA | alu_inB;
    endcase
  end

  task automatic issue(input alu_cmd_t cmd, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rslt !== 16'h0000 ||
        bus.rsp_cout !== 1'b0 || bus.rsp_illegal !== 1'b0 || bus.rsp_pari !== 1'b0 ||
        alu_cmd !== ADD0 || alu_inA !== 8'h00 || alu_sc_i !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b rslt=%h cout=%b ill=%b pari=%b cmd=%h inA=%h, required 1 0 0000 0 0 0 0 00",
               bus.req_ready, bus.rsp_valid, bus.rsp_rslt, bus.rsp_cout, bus.rsp_illegal,
               bus.rsp_pari, alu_cmd, alu_inA);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int e;
    issue(ADD0, 16'h00FF, 16'h0001, 1'b0);
    total++;
    if (alu_cmd !== ADD0 || alu_inA !== 8'hFF || alu_inB !== 8'h01 || alu_sc_i !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL add_byte0_drive: cmd=%h inA=%h inB=%h sc_i=%b valid=%b ready=%b, required 0 ff 01 0 0 0",
               alu_cmd, alu_inA, alu_inB, alu_sc_i, bus.rsp_valid, bus.req_ready);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (alu_inA !== 8'h00 || alu_inB !== 8'h00 || alu_sc_i !== 1'b1)
      $display("FAIL add_byte1_drive: inA=%h inB=%h sc_i=%b, required 00 00 1",
               alu_inA, alu_inB, alu_sc_i);
    else passed++;
    e = 1;
    while (bus.rsp_valid !== 1'b1 && e < 20) begin
      @(posedge clk);
      #1;
      e++;
    end
    total++;
    if (e !== 2) $display("FAIL add_latency: got %0d edges, required 2", e);
    else passed++;
    total++;
    if (bus.rsp_rslt !== 16'h0100 || bus.rsp_cout !== 1'b0 || bus.rsp_illegal !== 1'b0 ||
        bus.rsp_pari !== PAR_EN || alu_cmd !== ADD0)
      $display("FAIL add_result: rslt=%h cout=%b ill=%b pari=%b cmd=%h, required 0100 0 0 %b 0",
               bus.rsp_rslt, bus.rsp_cout, bus.rsp_illegal, bus.rsp_pari, alu_cmd, PAR_EN);
    else passed++;
    ack();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL add_return_idle: valid=%b ready=%b, required 0 1", bus.rsp_valid, bus.req_ready);
    else passed++;
  endtask

  task automatic test_add_carry();
    int e;
    issue(ADD1, 16'hFFFF, 16'h0001, 1'b0);
    wait_rsp(e);
    total++;
    if (e !== 2 || bus.rsp_rslt !== 16'h0000 || bus.rsp_cout !== 1'b1 || bus.rsp_pari !== 1'b0)
      $display("FAIL add_overflow: edges=%0d rslt=%h cout=%b pari=%b, required 2 0000 1 0",
               e, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari);
    else passed++;
    ack();
    issue(ADD7, 16'h0000, 16'h0000, 1'b1);
    wait_rsp(e);
    total++;
    if (e !== 2 || bus.rsp_rslt !== 16'h0001 || bus.rsp_cout !== 1'b0 || bus.rsp_pari !== PAR_EN)
      $display("FAIL add_cin: edges=%0d rslt=%h cout=%b pari=%b, required 2 0001 0 %b",
               e, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari, PAR_EN);
    else passed++;
    ack();
  endtask

  task automatic test_logic();
    int e;
    // A set carry-in must be ignored for non-add commands.
    issue(XOR, 16'hA5A5, 16'h0FF0, 1'b1);
    total++;
    if (alu_sc_i !== 1'b0)
      $display("FAIL xor_sc_i: got %b, required 0", alu_sc_i);
    else passed++;
    wait_rsp(e);
    total++;
    if (e !== 2 || bus.rsp_rslt !== 16'hAA55 || bus.rsp_cout !== 1'b0 || bus.rsp_pari !== 1'b0)
      $display("FAIL xor_result: edges=%0d rslt=%h cout=%b pari=%b, required 2 aa55 0 0",
               e, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari);
    else passed++;
    ack();
    issue(AND, 16'h1234, 16'h0F0F, 1'b0);
    wait_rsp(e);
    total++;
    if (e !== 2 || bus.rsp_rslt !== 16'h0204 || bus.rsp_cout !== 1'b0 || bus.rsp_pari !== 1'b0)
      $display("FAIL and_result: edges=%0d rslt=%h cout=%b pari=%b, required 2 0204 0 0",
               e, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari);
    else passed++;
    ack();
  endtask

  task automatic test_illegal();
    int e;
    // An illegal request goes straight to DONE, so rsp_valid is up right after the accepting edge.
    issue(ROT, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_rsp(e);
    total++;
    if (e !== 0 || bus.rsp_illegal !== 1'b1 || bus.rsp_rslt !== 16'h0000 ||
        bus.rsp_cout !== 1'b0 || bus.rsp_pari !== 1'b0 || alu_cmd !== ADD0)
      $display("FAIL illegal_rot: edges=%0d ill=%b rslt=%h cout=%b pari=%b cmd=%h, required 0 1 0000 0 0 0",
               e, bus.rsp_illegal, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari, alu_cmd);
    else passed++;
    ack();
    issue(OR, 16'h1234, 16'h4321, 1'b0);
    wait_rsp(e);
    total++;
    if (e !== 0 || bus.rsp_illegal !== 1'b1 || bus.rsp_rslt !== 16'h0000 || alu_cmd !== ADD0)
      $display("FAIL illegal_or: edges=%0d ill=%b rslt=%h cmd=%h, required 0 1 0000 0",
               e, bus.rsp_illegal, bus.rsp_rslt, alu_cmd);
    else passed++;
    ack();
  endtask

  task automatic test_hold();
    int e;
    // 0x7F80 + 0x0080: the low-byte carry ripples into the high byte.
    issue(ADD0, 16'h7F80, 16'h0080, 1'b0);
    wait_rsp(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_cmd   = XOR;
      bus.req_a     = 16'hFFFF;
      bus.req_b     = 16'h0000;
      bus.req_cin   = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rslt !== 16'h8000 || bus.rsp_cout !== 1'b0 ||
          bus.rsp_illegal !== 1'b0 || bus.rsp_pari !== PAR_EN || bus.req_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: valid=%b rslt=%h cout=%b ill=%b pari=%b ready=%b, required 1 8000 0 0 %b 0",
                 i, bus.rsp_valid, bus.rsp_rslt, bus.rsp_cout, bus.rsp_illegal, bus.rsp_pari,
                 bus.req_ready, PAR_EN);
      else passed++;
    end
    ack();
    bus.req_valid = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL hold_release: valid=%b ready=%b, required 0 1", bus.rsp_valid, bus.req_ready);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || alu_cmd !== ADD0 || bus.rsp_rslt !== 16'h8000)
      $display("FAIL hold_req_ignored: ready=%b cmd=%h rslt=%h, required 1 0 8000",
               bus.req_ready, alu_cmd, bus.rsp_rslt);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int e;
    issue(ADD0, 16'h00FF, 16'h00FF, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rslt !== 16'h0000 ||
        bus.rsp_cout !== 1'b0 || bus.rsp_illegal !== 1'b0 || bus.rsp_pari !== 1'b0 ||
        alu_cmd !== ADD0 || alu_inA !== 8'h00 || alu_inB !== 8'h00 || alu_sc_i !== 1'b0)
      $display("FAIL midrun_reset: ready=%b valid=%b rslt=%h cout=%b ill=%b pari=%b cmd=%h inA=%h inB=%h sc_i=%b, required 1 0 0000 0 0 0 0 00 00 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rslt, bus.rsp_cout, bus.rsp_illegal,
               bus.rsp_pari, alu_cmd, alu_inA, alu_inB, alu_sc_i);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    issue(ADD0, 16'h0001, 16'h0000, 1'b0);
    wait_rsp(e);
    total++;
    if (e !== 2 || bus.rsp_rslt !== 16'h0001 || bus.rsp_cout !== 1'b0 || bus.rsp_pari !== PAR_EN)
      $display("FAIL post_reset_add: edges=%0d rslt=%h cout=%b pari=%b, required 2 0001 0 %b",
               e, bus.rsp_rslt, bus.rsp_cout, bus.rsp_pari, PAR_EN);
    else passed++;
    ack();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = ADD0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_add_carry();
    test_logic();
    test_illegal();
    test_hold();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
